// File: rtl/grid_port_arbiter_if.sv
// Requester and RAM-side signal bundle of the placement grid port arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface grid_port_arbiter_if #(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 32
);
   logic [N_REQ-1:0]        req;
   logic [2*N_REQ-1:0]      op;
   logic [ADDR_W*N_REQ-1:0] addr;
   logic [DATA_W*N_REQ-1:0] wdata;
   logic [N_REQ-1:0]        gnt;
   logic [N_REQ-1:0]        done;
   logic [DATA_W-1:0]       rdata;
   logic                    claim_ok;
   logic                    busy;
   logic                    mem_re;
   logic                    mem_we;
   logic [ADDR_W-1:0]       mem_addr;
   logic [DATA_W-1:0]       mem_din;
   logic [DATA_W-1:0]       mem_dout;

   modport master (
      output req, op, addr, wdata, mem_dout,
      input  gnt, done, rdata, claim_ok, busy, mem_re, mem_we, mem_addr, mem_din
   );

   modport slave (
      input  req, op, addr, wdata, mem_dout,
      output gnt, done, rdata, claim_ok, busy, mem_re, mem_we, mem_addr, mem_din
   );
endinterface

// File: rtl/grid_port_arbiter.sv
// Round-robin arbiter for the single-port placement grid RAM with read, write
// and atomic claim (write only if the cell holds the empty marker).
module grid_port_arbiter #(
   parameter int unsigned       N_REQ  = 4,
   parameter int unsigned       ADDR_W = 12,
   parameter int unsigned       DATA_W = 32,
   parameter logic [DATA_W-1:0] EMPTY  = '1
) (
   input logic               clk,
   input logic               reset,
   grid_port_arbiter_if.slave bus
);
   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT_RD, S_CLAIM_CHK, S_DONE
   } state_t;

   typedef enum logic [1:0] {
      OP_READ = 2'b00, OP_WRITE = 2'b01, OP_CLAIM = 2'b10, OP_RSVD = 2'b11
   } op_t;

   state_t              state;
   logic [IDX_W-1:0]    rr_ptr;
   logic [IDX_W-1:0]    win_q;
   op_t                 op_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [N_REQ-1:0]    gnt_q;
   logic [N_REQ-1:0]    done_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                claim_ok_q;
   logic                busy_q;
   logic                mem_re_q;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_din_q;

   op_t                 op_a    [N_REQ];
   logic [ADDR_W-1:0]   addr_a  [N_REQ];
   logic [DATA_W-1:0]   wdata_a [N_REQ];

   logic                win_found;
   logic [IDX_W-1:0]    win_idx;
   logic [IDX_W-1:0]    scan_idx;
   int unsigned         scan_pos;

   // Unpack the flat per-requester operand buses
   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign op_a[g]    = op_t'(bus.op[2*g +: 2]);
      assign addr_a[g]  = bus.addr[ADDR_W*g +: ADDR_W];
      assign wdata_a[g] = bus.wdata[DATA_W*g +: DATA_W];
   end

   // First requesting index after rr_ptr, wrapping modulo N_REQ
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_pos  = 0;
      scan_idx  = '0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         scan_pos = (32'(rr_ptr) + i) % N_REQ;
         scan_idx = IDX_W'(scan_pos);
         if (!win_found && bus.req[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         rr_ptr     <= IDX_W'(N_REQ - 1);
         win_q      <= '0;
         op_q       <= OP_READ;
         wdata_q    <= '0;
         gnt_q      <= '0;
         done_q     <= '0;
         rdata_q    <= '0;
         claim_ok_q <= 1'b0;
         busy_q     <= 1'b0;
         mem_re_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
      end else begin
         mem_re_q <= 1'b0;
         mem_we_q <= 1'b0;
         done_q   <= '0;
         case (state)
            S_IDLE: begin
               if (win_found) begin
                  win_q      <= win_idx;
                  op_q       <= op_a[win_idx];
                  wdata_q    <= wdata_a[win_idx];
                  gnt_q      <= N_REQ'(1) << win_idx;
                  busy_q     <= 1'b1;
                  mem_addr_q <= addr_a[win_idx];
                  state      <= S_ISSUE;
                  // Strobes are registered here so they appear in the ISSUE cycle
                  case (op_a[win_idx])
                     OP_WRITE: begin
                        mem_we_q  <= 1'b1;
                        mem_din_q <= wdata_a[win_idx];
                     end
                     OP_READ, OP_CLAIM: mem_re_q <= 1'b1;
                     default: ;
                  endcase
               end
            end
            S_ISSUE: begin
               if (op_q == OP_READ || op_q == OP_CLAIM) begin
                  state <= S_WAIT_RD;
               end else begin
                  done_q     <= gnt_q;
                  claim_ok_q <= 1'b0;
                  state      <= S_DONE;
               end
            end
            S_WAIT_RD: begin
               rdata_q <= bus.mem_dout;
               if (op_q == OP_CLAIM) begin
                  // Claim write is strobed during CLAIM_CHK only if the cell was free
                  if (bus.mem_dout == EMPTY) begin
                     mem_we_q  <= 1'b1;
                     mem_din_q <= wdata_q;
                  end
                  state <= S_CLAIM_CHK;
               end else begin
                  done_q     <= gnt_q;
                  claim_ok_q <= 1'b0;
                  state      <= S_DONE;
               end
            end
            S_CLAIM_CHK: begin
               claim_ok_q <= (rdata_q == EMPTY);
               done_q     <= gnt_q;
               state      <= S_DONE;
            end
            S_DONE: begin
               gnt_q  <= '0;
               busy_q <= 1'b0;
               rr_ptr <= win_q;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.done     = done_q;
   assign bus.rdata    = rdata_q;
   assign bus.claim_ok = claim_ok_q;
   assign bus.busy     = busy_q;
   assign bus.mem_re   = mem_re_q;
   assign bus.mem_we   = mem_we_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_din  = mem_din_q;
endmodule

// File: tb/tb_grid_port_arbiter.sv
// Directed self-checking bench for grid_port_arbiter with a behavioural
// 1-cycle-latency grid RAM and a strobe/grant monitor.
module tb_grid_port_arbiter;
   localparam int unsigned N_REQ  = 4;
   localparam int unsigned ADDR_W = 12;
   localparam int unsigned DATA_W = 32;
   localparam logic [31:0] EMPTY  = 32'hFFFF_FFFF;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   grid_port_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   grid_port_arbiter #(
      .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .EMPTY(EMPTY)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   logic [31:0] ram [0:4095];
   always @(posedge clk) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
      if (bus.mem_re) bus.mem_dout <= ram[bus.mem_addr];
   end

   int checks = 0;
   int errors = 0;
   int we_cnt = 0;
   int re_cnt = 0;
   int both_cnt = 0;
   int gnt_log[$];
   logic [3:0] prev_gnt = '0;

   always @(posedge clk) begin
      if (bus.mem_we) we_cnt++;
      if (bus.mem_re) re_cnt++;
      if (bus.mem_we && bus.mem_re) both_cnt++;
      if (bus.gnt != 4'b0 && prev_gnt == 4'b0)
         for (int i = 0; i < 4; i++)
            if (bus.gnt == (4'b1 << i)) gnt_log.push_back(i);
      prev_gnt = bus.gnt;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int r, input logic [1:0] o, input logic [11:0] a, input logic [31:0] d);
      bus.op    = (bus.op & ~(8'h3 << (2*r))) | (8'(o) << (2*r));
      bus.addr  = (bus.addr & ~(48'hFFF << (12*r))) | (48'(a) << (12*r));
      bus.wdata = (bus.wdata & ~(128'hFFFF_FFFF << (32*r))) | (128'(d) << (32*r));
      bus.req   = bus.req | (4'b1 << r);
   endtask

   task automatic clr_req(input int r);
      bus.req = bus.req & ~(4'b1 << r);
   endtask

   // Drives one transaction and returns latency to done, first-cycle grant, done vector
   task automatic run_txn(input int r, input logic [1:0] o, input logic [11:0] a, input logic [31:0] d,
                          output int lat, output logic [3:0] g1, output logic [3:0] dn, output logic busy_ok);
      set_req(r, o, a, d);
      lat = -1; g1 = '0; dn = '0; busy_ok = 1'b1;
      for (int n = 1; n <= 20 && lat < 0; n++) begin
         cyc();
         if (n == 1) g1 = bus.gnt;
         if (!bus.busy) busy_ok = 1'b0;
         if (bus.done != 4'b0) begin lat = n; dn = bus.done; end
      end
      clr_req(r);
      cyc();
   endtask

   task automatic test_reset();
      cyc(); cyc();
      checks++; if (bus.gnt !== 4'b0 || bus.done !== 4'b0) begin errors++; $display("FAIL reset_gnt_done: gnt=%b done=%b expected 0", bus.gnt, bus.done); end
      checks++; if (bus.busy !== 1'b0 || bus.claim_ok !== 1'b0) begin errors++; $display("FAIL reset_busy_claim: busy=%b claim_ok=%b expected 0", bus.busy, bus.claim_ok); end
      checks++; if (bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0 || bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_mem: re=%b we=%b rdata=%h expected 0", bus.mem_re, bus.mem_we, bus.rdata); end
      reset = 1'b0;
   endtask

   task automatic test_write_read();
      int lat; logic [3:0] g1, dn; logic bok; int re0;
      run_txn(0, 2'b01, 12'h03A, 32'h5, lat, g1, dn, bok);
      checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d expected 2", lat); end
      checks++; if (g1 !== 4'b0001 || dn !== 4'b0001) begin errors++; $display("FAIL wr_gnt_done: gnt=%b done=%b expected 0001", g1, dn); end
      checks++; if (bok !== 1'b1) begin errors++; $display("FAIL wr_busy: busy dropped, expected high"); end
      re0 = re_cnt;
      run_txn(0, 2'b00, 12'h03A, 32'h0, lat, g1, dn, bok);
      checks++; if (lat !== 3 || dn !== 4'b0001) begin errors++; $display("FAIL rd_latency: lat=%0d done=%b expected 3/0001", lat, dn); end
      checks++; if (bus.rdata !== 32'h5 || bus.claim_ok !== 1'b0) begin errors++; $display("FAIL rd_data: rdata=%h claim_ok=%b expected 5/0", bus.rdata, bus.claim_ok); end
      checks++; if (bok !== 1'b1 || re_cnt - re0 !== 1) begin errors++; $display("FAIL rd_strobe: busy_ok=%b re=%0d expected 1/1", bok, re_cnt - re0); end
   endtask

   task automatic test_claim_empty();
      int lat; logic [3:0] g1, dn; logic bok; int we0;
      run_txn(1, 2'b01, 12'h010, EMPTY, lat, g1, dn, bok);
      we0 = we_cnt;
      run_txn(1, 2'b10, 12'h010, 32'h7, lat, g1, dn, bok);
      checks++; if (lat !== 4 || dn !== 4'b0010) begin errors++; $display("FAIL claim_latency: lat=%0d done=%b expected 4/0010", lat, dn); end
      checks++; if (bus.claim_ok !== 1'b1 || bus.rdata !== EMPTY) begin errors++; $display("FAIL claim_empty_result: claim_ok=%b rdata=%h expected 1/ffffffff", bus.claim_ok, bus.rdata); end
      checks++; if (ram[12'h010] !== 32'h7 || we_cnt - we0 !== 1) begin errors++; $display("FAIL claim_empty_ram: ram=%h we=%0d expected 7/1", ram[12'h010], we_cnt - we0); end
   endtask

   task automatic test_claim_occupied();
      int lat; logic [3:0] g1, dn; logic bok; int we0;
      we0 = we_cnt;
      run_txn(2, 2'b10, 12'h010, 32'h9, lat, g1, dn, bok);
      checks++; if (bus.claim_ok !== 1'b0 || bus.rdata !== 32'h7 || dn !== 4'b0100) begin errors++; $display("FAIL claim_occ_result: claim_ok=%b rdata=%h done=%b expected 0/7/0100", bus.claim_ok, bus.rdata, dn); end
      checks++; if (ram[12'h010] !== 32'h7 || we_cnt - we0 !== 0) begin errors++; $display("FAIL claim_occ_ram: ram=%h we=%0d expected 7/0", ram[12'h010], we_cnt - we0); end
   endtask

   task automatic test_fairness();
      int base; int exp_order[5] = '{0, 1, 2, 3, 0};
      reset = 1'b1; cyc(); reset = 1'b0;
      base = gnt_log.size();
      for (int i = 0; i < 4; i++) set_req(i, 2'b01, 12'(12'h100 + i), 32'(32'hA0 + i));
      for (int n = 0; n < 40 && gnt_log.size() < base + 5; n++) cyc();
      bus.req = '0;
      for (int n = 0; n < 10 && bus.busy; n++) cyc();
      cyc();
      checks++; if (gnt_log.size() < base + 5) begin errors++; $display("FAIL fair_count: got %0d grants expected 5", gnt_log.size() - base); end
      else for (int i = 0; i < 5; i++) begin
         checks++; if (gnt_log[base + i] !== exp_order[i]) begin errors++; $display("FAIL fair_order[%0d]: got %0d expected %0d", i, gnt_log[base + i], exp_order[i]); end
      end
      checks++; if (ram[12'h102] !== 32'hA2 || ram[12'h103] !== 32'hA3) begin errors++; $display("FAIL fair_ram: %h %h expected a2 a3", ram[12'h102], ram[12'h103]); end
   endtask

   task automatic test_contended_claim();
      int lat; logic [3:0] g1, dn; logic bok; int seen = 0;
      logic [3:0] dn1 = '0, dn2 = '0; logic ok1 = 1'b0, ok2 = 1'b1; logic [31:0] rd2 = '0;
      run_txn(3, 2'b01, 12'h020, EMPTY, lat, g1, dn, bok);
      set_req(0, 2'b10, 12'h020, 32'h11);
      set_req(3, 2'b10, 12'h020, 32'h33);
      for (int n = 0; n < 30 && seen < 2; n++) begin
         cyc();
         if (bus.done != 4'b0) begin
            if (seen == 0) begin dn1 = bus.done; ok1 = bus.claim_ok; clr_req(0); end
            else begin dn2 = bus.done; ok2 = bus.claim_ok; rd2 = bus.rdata; clr_req(3); end
            seen++;
         end
      end
      bus.req = '0;
      cyc();
      checks++; if (dn1 !== 4'b0001 || ok1 !== 1'b1) begin errors++; $display("FAIL contend_first: done=%b claim_ok=%b expected 0001/1", dn1, ok1); end
      checks++; if (dn2 !== 4'b1000 || ok2 !== 1'b0 || rd2 !== 32'h11) begin errors++; $display("FAIL contend_second: done=%b claim_ok=%b rdata=%h expected 1000/0/11", dn2, ok2, rd2); end
      checks++; if (ram[12'h020] !== 32'h11) begin errors++; $display("FAIL contend_ram: ram=%h expected 11", ram[12'h020]); end
   endtask

   task automatic test_reset_reserved();
      int lat = -1; int we0, re0, we1 = 0, re1 = 0; logic [3:0] g1 = '0, dn = '0, dn3 = '0; logic ok = 1'b1;
      logic [31:0] rd = '1;
      set_req(0, 2'b00, 12'h03A, 32'h0);
      cyc(); cyc();
      reset = 1'b1;
      #1;
      checks++; if (bus.gnt !== 4'b0 || bus.done !== 4'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL async_reset: gnt=%b done=%b busy=%b expected 0", bus.gnt, bus.done, bus.busy); end
      bus.req = '0;
      cyc();
      reset = 1'b0;
      set_req(3, 2'b01, 12'h050, 32'h55);
      set_req(0, 2'b11, 12'h060, 32'h66);
      we0 = we_cnt; re0 = re_cnt;
      for (int n = 1; n <= 20 && lat < 0; n++) begin
         cyc();
         if (n == 1) g1 = bus.gnt;
         if (bus.done != 4'b0) begin lat = n; dn = bus.done; ok = bus.claim_ok; rd = bus.rdata; we1 = we_cnt - we0; re1 = re_cnt - re0; end
      end
      clr_req(0);
      for (int n = 0; n < 20 && dn3 == 4'b0; n++) begin cyc(); dn3 = bus.done; end
      bus.req = '0;
      cyc();
      checks++; if (g1 !== 4'b0001) begin errors++; $display("FAIL post_reset_winner: gnt=%b expected 0001", g1); end
      checks++; if (lat !== 2 || dn !== 4'b0001 || ok !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL rsvd_done: lat=%0d done=%b claim_ok=%b rdata=%h expected 2/0001/0/0", lat, dn, ok, rd); end
      checks++; if (we1 !== 0 || re1 !== 0) begin errors++; $display("FAIL rsvd_strobe: we=%0d re=%0d expected 0/0", we1, re1); end
      checks++; if (dn3 !== 4'b1000 || ram[12'h050] !== 32'h55) begin errors++; $display("FAIL rsvd_next: done=%b ram=%h expected 1000/55", dn3, ram[12'h050]); end
      checks++; if (both_cnt !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d cycles expected 0", both_cnt); end
   endtask

   initial begin
      bus.req = '0; bus.op = '0; bus.addr = '0; bus.wdata = '0;
      test_reset();
      test_write_read();
      test_claim_empty();
      test_claim_occupied();
      test_fairness();
      test_contended_claim();
      test_reset_reserved();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
